// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-digit BCD counter.
// Contents:
//   BCD_W       - width of one BCD digit
//   BCD_MAX     - largest legal BCD digit value
//   bcd_digit_t - one BCD digit
//   bcd_clamp   - maps any illegal digit (>9) to 9
package bcd_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter's next-value chain (purely combinational).
// Ports:
//   digit_i - current value of this digit
//   inc_i   - chain counts upward
//   dec_i   - chain counts downward (ignored when inc_i is set)
//   cin_i   - carry-in (up) / borrow-in (down) from the next lower digit
//   digit_o - value this digit takes if the chain steps
//   cout_o  - carry-out (9->0 going up) / borrow-out (0->9 going down)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       cin_i,
    output logic [3:0] digit_o,
    output logic       cout_o
);

    always_comb begin
        digit_o = digit_i;
        cout_o  = 1'b0;
        if (cin_i) begin
            if (inc_i) begin
                if (digit_i == BCD_MAX) begin
                    digit_o = '0;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i + 4'd1;
                end
            end else if (dec_i) begin
                if (digit_i == '0) begin
                    digit_o = BCD_MAX;
                    cout_o  = 1'b1;
                end else begin
                    digit_o = digit_i - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_multi.sv
// Multi-digit up/down BCD counter with clear, clamped parallel load, output freeze and a
// registered wrap/borrow pulse for cascading.
// Build option: define BCD_CNT_SATURATE_EN to stop at MAX_VAL (up) / 0 (down) instead of
// wrapping; carry then pulses once on the edge that reaches the limit.
// Ports:
//   clk_i       - system clock
//   rst_ni      - asynchronous active-low reset
//   clken_i     - count enable, one step per enabled edge
//   clr_i       - synchronous clear (highest priority)
//   up_dn_i     - 1 = count up, 0 = count down
//   load_i      - synchronous parallel load (below clr, above clken)
//   load_data_i - BCD load value, digit 0 in bits [3:0]
//   freeze_i    - hold data_o while the internal count keeps running
//   data_o      - registered BCD count
//   carry_o     - registered one-cycle pulse on wrap/borrow
//   busy_max_o  - combinational: internal count at MAX_VAL (up) or 0 (down)
module bcd_counter_multi
    import bcd_pkg::*;
#(
    parameter int unsigned              DIGITS  = 4,
    parameter logic [4*DIGITS-1:0]      MAX_VAL = {DIGITS{4'h9}}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clken_i,
    input  logic                  clr_i,
    input  logic                  up_dn_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_data_i,
    input  logic                  freeze_i,
    output logic [4*DIGITS-1:0]   data_o,
    output logic                  carry_o,
    output logic                  busy_max_o
);

    localparam int unsigned W = BCD_W * DIGITS;

    logic [W-1:0]    count_q, count_d;
    logic [W-1:0]    data_q, data_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    step_val;
    logic [W-1:0]    load_clamped;
    logic [DIGITS:0] chain;
    logic            at_limit;

    // The digit chain always runs in the current direction; clken only gates whether the
    // stepped value is taken. This keeps the top borrow-out meaningful as a zero detect.
    assign chain[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .digit_i (count_q[i*BCD_W +: BCD_W]),
            .inc_i   (up_dn_i),
            .dec_i   (~up_dn_i),
            .cin_i   (chain[i]),
            .digit_o (step_val[i*BCD_W +: BCD_W]),
            .cout_o  (chain[i+1])
        );
    end

    // Going down, a borrow out of the top digit means every digit was 0.
    assign at_limit   = up_dn_i ? (count_q == MAX_VAL) : chain[DIGITS];
    assign busy_max_o = at_limit;

    // Illegal digits become 9 first, then the whole value is capped at MAX_VAL.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(load_data_i[i*BCD_W +: BCD_W]);
        end
        if (load_clamped > MAX_VAL) begin
            load_clamped = MAX_VAL;
        end
    end

    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_clamped;
        end else if (clken_i) begin
`ifdef BCD_CNT_SATURATE_EN
            if (!at_limit) begin
                count_d = step_val;
                carry_d = up_dn_i ? (step_val == MAX_VAL) : (step_val == '0);
            end
`else
            if (at_limit) begin
                count_d = up_dn_i ? '0 : MAX_VAL;
                carry_d = 1'b1;
            end else begin
                count_d = step_val;
            end
`endif
        end
    end

    // data_o follows the value produced at this edge, so it adds no latency over the count.
    assign data_d = freeze_i ? data_q : count_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            count_q <= count_d;
            data_q  <= data_d;
            carry_q <= carry_d;
        end
    end

    assign data_o  = data_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Scoreboard bench for bcd_counter_multi (DIGITS=2). The stimulus process drives inputs on
// the falling edge and pushes the response expected after the next rising edge, computed
// from a decimal-integer model; a monitor pops and compares just after each rising edge.
module tb_bcd_counter_multi;

`ifdef BCD_CNT_SATURATE_EN
    localparam int         MAXI = 59;
    localparam logic [7:0] MAXB = 8'h59;
`else
    localparam int         MAXI = 99;
    localparam logic [7:0] MAXB = 8'h99;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clken = 1'b0, clr = 1'b0, up_dn = 1'b1, load = 1'b0, freeze = 1'b0;
    logic [7:0] load_data = '0;
    logic [7:0] data;
    logic       carry, busy_max;

    bcd_counter_multi #(
        .DIGITS  (2),
        .MAX_VAL (MAXB)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clken_i     (clken),
        .clr_i       (clr),
        .up_dn_i     (up_dn),
        .load_i      (load),
        .load_data_i (load_data),
        .freeze_i    (freeze),
        .data_o      (data),
        .carry_o     (carry),
        .busy_max_o  (busy_max)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;
    int   m_data = 0;
    logic rst_req = 1'b0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'(v / 10);
        return r;
    endfunction

    // Each digit above 9 reads as 9, then the decimal value is capped at the terminal count.
    function automatic int load_value(input logic [7:0] b);
        int lo, hi, v;
        lo = (int'(b[3:0]) > 9) ? 9 : int'(b[3:0]);
        hi = (int'(b[7:4]) > 9) ? 9 : int'(b[7:4]);
        v  = hi * 10 + lo;
        return (v > MAXI) ? MAXI : v;
    endfunction

    task automatic cyc(input logic c_clr, input logic c_ld, input logic [7:0] c_ldd,
                       input logic c_en, input logic c_up, input logic c_frz);
        exp_t e;
        logic car;
        @(negedge clk);
        rst_n     = rst_req;
        clr       = c_clr;
        load      = c_ld;
        load_data = c_ldd;
        clken     = c_en;
        up_dn     = c_up;
        freeze    = c_frz;
        car = 1'b0;
        if (!rst_req) begin
            m_cnt  = 0;
            m_data = 0;
        end else begin
            if (c_clr) begin
                m_cnt = 0;
            end else if (c_ld) begin
                m_cnt = load_value(c_ldd);
            end else if (c_en) begin
`ifdef BCD_CNT_SATURATE_EN
                if (c_up && m_cnt < MAXI) begin
                    m_cnt++;
                    car = (m_cnt == MAXI);
                end else if (!c_up && m_cnt > 0) begin
                    m_cnt--;
                    car = (m_cnt == 0);
                end
`else
                if (c_up) begin
                    if (m_cnt == MAXI) begin
                        m_cnt = 0;
                        car = 1'b1;
                    end else begin
                        m_cnt++;
                    end
                end else begin
                    if (m_cnt == 0) begin
                        m_cnt = MAXI;
                        car = 1'b1;
                    end else begin
                        m_cnt--;
                    end
                end
`endif
            end
            if (!c_frz) m_data = m_cnt;
        end
        e.d = to_bcd(m_data);
        e.c = car;
        e.b = c_up ? (m_cnt == MAXI) : (m_cnt == 0);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, up_dn, 1'b0);
    endtask

    task automatic count(input int n, input logic up, input logic frz);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, up, frz);
    endtask

    task automatic do_load(input logic [7:0] v);
        cyc(1'b0, 1'b1, v, 1'b0, up_dn, 1'b0);
    endtask

    task automatic check_now(input string name, input logic [7:0] d, input logic c);
        checks++;
        if (data !== d || carry !== c) begin
            failures++;
            $display("FAIL %s: data=%h carry=%b, expected data=%h carry=%b", name, data, carry,
                     d, c);
        end
    endtask

    // Monitor: the DUT presents a result after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks += 3;
                if (data !== e.d) begin
                    failures++;
                    $display("FAIL data @%0t: got %h expected %h", $time, data, e.d);
                end
                if (carry !== e.c) begin
                    failures++;
                    $display("FAIL carry @%0t: got %b expected %b", $time, carry, e.c);
                end
                if (busy_max !== e.b) begin
                    failures++;
                    $display("FAIL busy_max @%0t: got %b expected %b", $time, busy_max, e.b);
                end
            end
        end
    end

    initial begin
        exp_t e;
        #1;
        check_now("reset_state", 8'h00, 1'b0);
        idle(2);
        rst_req = 1'b1;

        // Full upward sweep through the wrap.
        count(MAXI + 3, 1'b1, 1'b0);

        // Downward from 05 through the borrow.
        do_load(8'h05);
        count(7, 1'b0, 1'b0);

        // Clamped loads, and clear beating load.
        do_load(8'h3A);
        idle(1);
        do_load(8'hAB);
        do_load(8'h75);
        cyc(1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0);
        idle(1);

        // Freeze while counting, then a wrap hidden behind freeze.
        do_load(8'h10);
        count(2, 1'b1, 1'b0);
        count(5, 1'b1, 1'b1);
        count(2, 1'b1, 1'b0);
        do_load(MAXB - 8'h01);
        count(4, 1'b1, 1'b1);
        count(1, 1'b1, 1'b0);

`ifdef BCD_CNT_SATURATE_EN
        do_load(8'h57);
        count(5, 1'b1, 1'b0);
        do_load(8'h01);
        count(4, 1'b0, 1'b0);
`endif

        // Asynchronous reset between edges at 47.
        do_load(8'h40);
        count(7, 1'b1, 1'b0);
        count(1, 1'b1, 1'b0);
        #2;
        rst_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_now("async_reset", 8'h00, 1'b0);
        // The edge already scheduled now sees reset held low.
        void'(q.pop_back());
        m_cnt = 0;
        m_data = 0;
        e.d = 8'h00;
        e.c = 1'b0;
        e.b = up_dn ? (MAXI == 0) : 1'b1;
        q.push_back(e);
        count(3, 1'b1, 1'b0);
        rst_req = 1'b1;
        count(3, 1'b1, 1'b0);

        // Randomised phase.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(15) == 0), ($urandom_range(9) == 0), 8'($urandom),
                ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(5) == 0));
        end

        idle(2);
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
